// File: rtl/instr_mem_loader.sv
//------------------------------------------------------------------------------
// Module      : instr_mem_loader
// Description : Instruction store for a 4-bit fetch interface, with a
//               byte-serial program-load port (high byte first). While a
//               load is in progress the fetch output is forced to NOP so
//               the core never executes a half-written program.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               address          - fetch address from the core
//               instruction      - registered instruction (1-cycle latency)
//               load_start       - pulse: begin/restart a load at word 0
//               load_end         - pulse: terminate the load early
//               load_valid       - load_byte valid this cycle
//               load_byte        - program byte, high byte of each word first
//               load_ready       - block accepts a byte this cycle
//               loading          - a load is in progress
//               load_done        - one-cycle pulse when a load completes/ends
//               load_count       - words written by the current or last load
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_mem_loader #(
  parameter int          DEPTH    = 16,
  parameter int          ADDR_W   = 4,
  parameter int          DATA_W   = 16,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              loading,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_HI   = 2'd1;
  localparam logic [1:0] c_LO   = 2'd2;

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_hi_byte;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_active;
  logic w_we;

  assign w_active = (r_state == c_HI) || (r_state == c_LO);

  // load_start and load_end both outrank a byte, so a word is only committed
  // when neither is asserted alongside the low byte.
  assign w_we = (r_state == c_LO) && load_valid && !load_start && !load_end;

  assign load_ready  = w_active;
  assign loading     = w_active;
  assign load_done   = r_done;
  assign load_count  = r_count;
  assign instruction = r_instr;

  // Memory array and read port. The read uses the pre-edge loading flag, so
  // the edge on which a load ends still returns NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= NOP_WORD;
      end
      r_instr <= NOP_WORD;
    end else begin
      if (w_we) begin
        r_mem[r_ptr] <= {r_hi_byte, load_byte};
      end
      r_instr <= w_active ? NOP_WORD : r_mem[address];
    end
  end

  // Load sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_ptr     <= '0;
      r_hi_byte <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load_start) begin
        // Start or restart; a restart never produces a done pulse.
        r_state   <= c_HI;
        r_ptr     <= '0;
        r_count   <= '0;
        r_hi_byte <= '0;
      end else begin
        case (r_state)
          c_HI: begin
            if (load_end) begin
              r_state <= c_IDLE;
              r_done  <= 1'b1;
            end else if (load_valid) begin
              r_hi_byte <= load_byte;
              r_state   <= c_LO;
            end
          end
          c_LO: begin
            if (load_end) begin
              // Pending high byte is dropped; no partial word is written.
              r_state   <= c_IDLE;
              r_done    <= 1'b1;
              r_hi_byte <= '0;
            end else if (load_valid) begin
              r_count <= r_count + 1'b1;
              if (r_ptr == c_LAST) begin
                // Memory full: finish without wrapping the pointer.
                r_state <= c_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_ptr   <= r_ptr + 1'b1;
                r_state <= c_HI;
              end
            end
          end
          default: begin
            r_state <= c_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none

module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  address = '0;
  logic [15:0] instruction;
  logic        load_start = 1'b0;
  logic        load_end = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_ready;
  logic        loading;
  logic        load_done;
  logic [4:0]  load_count;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] model [16];
  int          mptr = 0;
  logic [15:0] exp_q [$];

  instr_mem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .instruction (instruction),
    .load_start  (load_start),
    .load_end    (load_end),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_ready  (load_ready),
    .loading     (loading),
    .load_done   (load_done),
    .load_count  (load_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard read: expected word is queued when the address is driven and
  // popped when the registered output is produced one edge later.
  task automatic read_check(input logic [3:0] a);
    logic [15:0] e;
    address = a;
    exp_q.push_back(model[a]);
    tick();
    e = exp_q.pop_front();
    check($sformatf("read[%0d]", a), {16'h0, instruction}, {16'h0, e});
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) read_check(4'(a));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    mptr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    load_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      check("ready_in_stall", {31'h0, load_ready}, 32'd1);
    end
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap_hi, input int gap_lo);
    send_byte(w[15:8], gap_hi);
    send_byte(w[7:0], gap_lo);
    model[mptr] = w;
    mptr++;
    check("nop_during_load", {16'h0, instruction}, 32'h0);
  endtask

  task automatic end_load();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    // Reset state and cleared memory.
    do_reset();
    check("rst_loading", {31'h0, loading}, 32'd0);
    check("rst_ready", {31'h0, load_ready}, 32'd0);
    check("rst_done", {31'h0, load_done}, 32'd0);
    check("rst_count", {27'h0, load_count}, 32'd0);
    check("rst_instr", {16'h0, instruction}, 32'h0);
    read_all();

    // load_valid in IDLE is ignored.
    load_valid = 1'b1;
    load_byte  = 8'h5A;
    tick();
    tick();
    load_valid = 1'b0;
    check("idle_valid_loading", {31'h0, loading}, 32'd0);

    // Back-to-back full load.
    start_load();
    check("start_loading", {31'h0, loading}, 32'd1);
    check("start_ready", {31'h0, load_ready}, 32'd1);
    for (int i = 0; i < 16; i++) send_word({8'(8'h10 + i), 8'h05}, 0, 0);
    check("full_done", {31'h0, load_done}, 32'd1);
    check("full_loading", {31'h0, loading}, 32'd0);
    check("full_count", {27'h0, load_count}, 32'd16);
    tick();
    check("full_done_one_cycle", {31'h0, load_done}, 32'd0);
    check("full_count_held", {27'h0, load_count}, 32'd16);
    read_check(4'd3);
    read_all();

    // Same image with stalls (first word uses the 1,0,0,1 pattern).
    do_reset();
    read_check(4'd3);
    start_load();
    send_word(16'h1005, 0, 2);
    for (int i = 1; i < 16; i++)
      send_word({8'(8'h10 + i), 8'h05}, $urandom_range(0, 2), $urandom_range(0, 2));
    check("gap_done", {31'h0, load_done}, 32'd1);
    check("gap_count", {27'h0, load_count}, 32'd16);
    tick();
    read_all();

    // Three words, then load_end while waiting for a high byte.
    start_load();
    send_word(16'h1A01, 0, 0);
    send_word(16'h2210, 1, 0);
    send_word(16'h3450, 0, 1);
    end_load();
    check("end_hi_done", {31'h0, load_done}, 32'd1);
    check("end_hi_count", {27'h0, load_count}, 32'd3);
    check("end_hi_loading", {31'h0, loading}, 32'd0);
    tick();
    check("end_hi_done_clear", {31'h0, load_done}, 32'd0);
    for (int a = 0; a < 4; a++) read_check(4'(a));

    // High byte sent, then load_end together with a low byte.
    start_load();
    send_word(16'h7777, 0, 0);
    send_byte(8'hAB, 0);
    load_end   = 1'b1;
    load_valid = 1'b1;
    load_byte  = 8'hCD;
    tick();
    load_end   = 1'b0;
    load_valid = 1'b0;
    check("end_lo_done", {31'h0, load_done}, 32'd1);
    check("end_lo_count", {27'h0, load_count}, 32'd1);
    tick();
    for (int a = 0; a < 3; a++) read_check(4'(a));

    // Restart after five words.
    start_load();
    for (int i = 0; i < 5; i++) send_word({8'hC0, 8'(i)}, 0, 0);
    check("pre_restart_count", {27'h0, load_count}, 32'd5);
    start_load();
    check("restart_count", {27'h0, load_count}, 32'd0);
    check("restart_loading", {31'h0, loading}, 32'd1);
    check("restart_no_done", {31'h0, load_done}, 32'd0);
    send_word(16'hBEEF, 0, 0);
    end_load();
    check("restart_end_count", {27'h0, load_count}, 32'd1);
    tick();
    for (int a = 0; a < 6; a++) read_check(4'(a));

    // Reset in the middle of a load.
    start_load();
    send_word(16'h9999, 0, 0);
    send_byte(8'h88, 0);
    do_reset();
    check("midrst_loading", {31'h0, loading}, 32'd0);
    check("midrst_done", {31'h0, load_done}, 32'd0);
    check("midrst_count", {27'h0, load_count}, 32'd0);
    tick();
    check("midrst_done_later", {31'h0, load_done}, 32'd0);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
